fp_to_linear_decoder: RTL and testbench
=======================================

Name: fp_to_linear_decoder

Overview:
- Sequential decoder that expands the lab2 8-bit floating-point code (sign S, 3-bit exponent E, 4-bit significand F) back into a 12-bit two's-complement linear value D = (-1)^S * F * 2^E.
- Inverse partner of the lab2 linear-to-float converter. Used for round-trip checking and downstream arithmetic.
- Uses a valid/ready handshake on both sides. Applies the exponent with a one-bit-per-cycle shifter.

Parameters:
- E_W, 3, exponent width (fixed; other values unsupported)
- F_W, 4, significand width (fixed)
- D_W, 12, output width; must satisfy D_W >= F_W + 2^E_W (= 12)

Ports:
- clk  input  1  system clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  S/E/F presented
- in_ready  output  1  decoder can accept a code
- S  input  1  sign
- E  input  3  exponent
- F  input  4  significand, unsigned
- out_valid  output  1  D holds a result
- out_ready  input  1  consumer accepts D
- D  output  12  two's-complement result
- busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, D=0, busy=0, internal mag=0, cnt=0, sgn=0.
- FSM states: IDLE, SHIFT, SIGN, HOLD. All outputs are registered or decoded from state only.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture sgn<=S, cnt<=E, mag<={7'b0,F} (11-bit), then go to SHIFT.
  - No in_valid: stay in IDLE.
- SHIFT:
  - in_ready=0.
  - If cnt!=0: mag<=mag<<1 and cnt<=cnt-1, stay in SHIFT.
  - If cnt==0: go to SIGN.
  - SHIFT therefore occupies E+1 cycles.
- SIGN:
  - D <= sgn ? -{1'b0,mag} : {1'b0,mag}, in 12-bit two's complement.
  - Set out_valid<=1, go to HOLD.
- HOLD:
  - out_valid=1; D is stable and unchanged.
  - If out_ready: out_valid<=0, go to IDLE. D keeps its last value until the next SIGN.
  - If !out_ready: stay in HOLD indefinitely.
- Latency: out_valid rises on the (E+2)th rising edge after the accept edge, i.e. 2 to 9 cycles.
- Throughput: one code per E+4 cycles minimum. in_ready returns to 1 the cycle after the out_valid&&out_ready handshake.
- Arithmetic: the magnitude is at most 15*128 = 1920 (11 bits), so no overflow or saturation is possible.
  - Range of D: -1920 to +1920.
  - -0 (S=1, F=0) yields D=0.
  - F=0 with any E yields 0 after the full E+1 SHIFT cycles; there is no early exit.
- in_valid while busy: ignored, no capture. The source must hold its code until it sees in_ready.
- Changing S/E/F after accept has no effect on the operation in progress.
- Reset mid-operation: asynchronous return to reset values. The in-flight code is discarded and no out_valid is produced.
- out_ready asserted while out_valid=0: ignored.

Test Plan:
- Reset, then accept S=0,E=0,F=0 -> out_valid on 2nd edge after accept, D=12'h000; release with out_ready=1 -> in_ready=1 next cycle.
- S=0,E=7,F=15 -> D=12'h780 (+1920); out_valid rises exactly 9 edges after accept; busy high throughout.
- S=1,E=7,F=15 -> D=12'h880 (-1920). S=1,E=3,F=9 -> D=12'hFB8 (-72). S=1,E=5,F=0 -> D=12'h000.
- Backpressure: S=0,E=2,F=5 with out_ready=0 for 20 cycles -> out_valid and D=12'h014 held stable; a new in_valid during the wait is not accepted; raise out_ready -> one handshake, then the new code is accepted.
- Reset mid-SHIFT: accept E=6, drop rst_n for 1 ns after 3 cycles -> all outputs return to reset values immediately; no out_valid follows; the next code decodes correctly.
- Exhaustive sweep over all 256 (S,E,F) codes with random out_ready stalls -> D equals (-1)^S*F*2^E for every code, and each code produces exactly one result.

Source files
------------

// File: rtl/fp_to_linear_decoder_if.sv
// fp_to_linear_decoder_if: code input and linear result handshake bundle for the decoder.
interface fp_to_linear_decoder_if #(
  parameter int E_W = 3,
  parameter int F_W = 4,
  parameter int D_W = 12
);
  logic           in_valid;
  logic           in_ready;
  logic           S;
  logic [E_W-1:0] E;
  logic [F_W-1:0] F;
  logic           out_valid;
  logic           out_ready;
  logic [D_W-1:0] D;
  logic           busy;
  modport master (
    output in_valid, S, E, F, out_ready,
    input  in_ready, out_valid, D, busy
  );
  modport slave (
    input  in_valid, S, E, F, out_ready,
    output in_ready, out_valid, D, busy
  );
endinterface

// File: rtl/fp_to_linear_decoder.sv
// fp_to_linear_decoder: expands an 8-bit S/E/F float code into a signed linear value,
// applying the exponent one bit per cycle.
module fp_to_linear_decoder #(
  parameter int E_W = 3,
  parameter int F_W = 4,
  parameter int D_W = 12
) (
  input logic clk,
  input logic rst_n,
  fp_to_linear_decoder_if.slave bus
);
  localparam int M_W = D_W - 1;
  typedef enum logic [1:0] {IDLE, SHIFT, SIGN, HOLD} state_t;
  state_t state, next;
  logic [M_W-1:0] mag;
  logic [E_W-1:0] cnt;
  logic           sgn;
  logic [D_W-1:0] d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= next;
  end
  always_comb begin
    next = state;
    case (state)
      IDLE:  next = bus.in_valid ? SHIFT : IDLE;
      SHIFT: next = (cnt == '0) ? SIGN : SHIFT;
      SIGN:  next = HOLD;
      HOLD:  next = bus.out_ready ? IDLE : HOLD;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    bus.in_ready  = state == IDLE;
    bus.out_valid = state == HOLD;
    bus.busy      = state != IDLE;
    bus.D         = d;
  end
  // zero-significand codes still run the full E+1 shift cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag <= '0;
      cnt <= '0;
      sgn <= 1'b0;
      d   <= '0;
    end else if (state == IDLE && bus.in_valid) begin
      mag <= {{(M_W-F_W){1'b0}}, bus.F};
      cnt <= bus.E;
      sgn <= bus.S;
    end else if (state == SHIFT && cnt != '0) begin
      mag <= mag << 1;
      cnt <= cnt - 1'b1;
    end else if (state == SIGN) begin
      d <= sgn ? -{1'b0, mag} : {1'b0, mag};
    end
  end
endmodule

// File: tb/tb_fp_to_linear_decoder.sv
// tb_fp_to_linear_decoder: randomized and directed checks of the float-code decoder
// against an arithmetic reference (-1)^S * F * 2^E.
module tb_fp_to_linear_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  fp_to_linear_decoder_if bus ();
  fp_to_linear_decoder dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_d(input logic s, input logic [2:0] e, input logic [3:0] f);
    int v;
    v = int'(f) * (1 << e);
    if (s) v = -v;
    return 32'(v) & 32'hfff;
  endfunction

  task automatic check_idle(input string tag, input logic [31:0] d_exp);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 1);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_D"}, 32'(bus.D), d_exp);
  endtask

  // drive one code, check latency/result, hold for stall cycles, then release
  task automatic run(input logic s, input logic [2:0] e, input logic [3:0] f,
                     input int stall, input logic poke);
    int n;
    logic [31:0] exp;
    exp = ref_d(s, e, f);
    bus.in_valid = 1'b1; bus.S = s; bus.E = e; bus.F = f;
    n = 0;
    while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("accept_ready", 32'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.S = 1'($urandom); bus.E = 3'($urandom); bus.F = 4'($urandom);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      if (!bus.busy) check("busy_run", 32'(bus.busy), 1);
      @(posedge clk); #1; n++;
    end
    check("latency", n, e + 2);
    check("D", 32'(bus.D), exp);
    for (int i = 0; i < stall; i++) begin
      if (poke) begin
        bus.in_valid = 1'b1; bus.S = 1'b1; bus.E = 3'd1; bus.F = 4'd3;
        check("hold_in_ready", 32'(bus.in_ready), 0);
      end
      @(posedge clk); #1;
      check("hold_valid", 32'(bus.out_valid), 1);
      check("hold_D", 32'(bus.D), exp);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check_idle("release", exp);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.S = 1'b0; bus.E = '0; bus.F = '0;
    #1;
    check_idle("reset", 0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle("post_reset", 0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("stray_out_ready", 32'(bus.out_valid), 0);
    bus.out_ready = 1'b0;
    run(1'b0, 3'd0, 4'd0, 0, 1'b0);
    run(1'b0, 3'd7, 4'd15, 1, 1'b0);
    run(1'b1, 3'd7, 4'd15, 0, 1'b0);
    run(1'b1, 3'd3, 4'd9, 2, 1'b0);
    run(1'b1, 3'd5, 4'd0, 0, 1'b0);
    run(1'b0, 3'd2, 4'd5, 20, 1'b1);
    run(1'b1, 3'd1, 4'd3, 0, 1'b0);
    // asynchronous reset three cycles into a long shift
    run(1'b0, 3'd4, 4'd11, 0, 1'b0);
    bus.in_valid = 1'b1; bus.S = 1'b0; bus.E = 3'd6; bus.F = 4'd7;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_idle("mid_reset", 0);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) check("no_valid_after_reset", 32'(bus.out_valid), 0);
    end
    check_idle("after_reset_idle", 0);
    run(1'b1, 3'd2, 4'd6, 0, 1'b0);
    for (int c = 0; c < 256; c++) begin
      logic [7:0] code;
      code = 8'(c);
      run(code[7], code[6:4], code[3:0], int'($urandom_range(0, 3)), 1'b0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
